bitrev_scatter_buffer: RTL and testbench

//  Frame reorder buffer: accepts a complex sample stream whose frames arrive in
//  bit-reversed index order (e.g. raw pipelined-FFT/IFFT output) and emits the

---
 rtl/fft_pkg.sv | 22 ++
 rtl/bitrev_dpram.sv | 34 +++
 rtl/bitrev_scatter_buffer.sv | 154 +++++++++++++++
 tb/tb_bitrev_scatter_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath blocks: default sizes, the
// bit-reversal helper and the reorder-buffer write-FSM encoding.
package fft_pkg;

    localparam int LGSIZE_DEF = 6;
    localparam int WIDTH_DEF  = 16;
    localparam int BITREV_MAX = 16;

    localparam logic [0:0] W_HUNT = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;

    // Reverses the low nbits of v; bits above nbits come back as zero.
    function automatic logic [BITREV_MAX-1:0] bitrev(
        input logic [BITREV_MAX-1:0] v,
        input int unsigned           nbits
    );
        logic [BITREV_MAX-1:0] r;
        r = {<<{v}};
        return r >> (BITREV_MAX - nbits);
    endfunction

endpackage

// File: rtl/bitrev_dpram.sv
// Simple dual-port RAM: one write port, one read port whose output register
// only updates on read enable (so it doubles as the holding output stage).
module bitrev_dpram #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Array contents are never reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/bitrev_scatter_buffer.sv
// Frame reorder buffer: scatter-writes bit-reversed frames into ping-pong banks
// and gathers them linearly, emitting natural-order frames under valid/ready.
module bitrev_scatter_buffer
    import fft_pkg::*;
#(
    parameter int LGSIZE = LGSIZE_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_sync,
    input  logic [2*WIDTH-1:0] i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_data,
    output logic               o_first,
    output logic               o_last,
    output logic               o_sync_err,
    output logic [0:0]         o_wstate_dbg
);

    // Handshake: a beat moves on a port only on a clock edge where that
    // port's valid and ready are both high; valid never waits on ready, and
    // output data/flags stay frozen while o_valid is high and i_ready is low.

    localparam logic [LGSIZE-1:0] CNT_LAST = {LGSIZE{1'b1}};

    logic [0:0]        wstate;
    logic              wbank;
    logic              rbank;
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic [LGSIZE-1:0] wcnt;
    logic [LGSIZE-1:0] rcnt;
    logic              valid_q;
    logic              first_q;
    logic              last_q;
    logic              sync_err_q;

    logic              accept;
    logic              resync;
    logic              we;
    logic              frame_done;
    logic              issue;
    logic              read_done;
    logic [LGSIZE-1:0] wr_idx;

    assign o_ready = !full[wbank];
    assign accept  = i_valid && o_ready;

    // A sync seen part-way into a frame restarts that frame in the same bank.
    assign resync     = accept && i_sync && (wstate == W_FILL) && (wcnt != '0);
    assign we         = accept && ((wstate == W_FILL) || i_sync);
    assign frame_done = accept && (wstate == W_FILL) && !resync && (wcnt == CNT_LAST);
    assign wr_idx     = i_sync ? '0 : LGSIZE'(bitrev(BITREV_MAX'(wcnt), LGSIZE));

    assign issue     = full[rbank] && (!valid_q || i_ready);
    assign read_done = issue && (rcnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wstate     <= W_HUNT;
            wcnt       <= '0;
            wbank      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= resync;
            case (wstate)
                W_HUNT: begin
                    if (accept && i_sync) begin
                        wstate <= W_FILL;
                        wcnt   <= LGSIZE'(1);
                    end
                end
                W_FILL: begin
                    if (resync) begin
                        wcnt <= LGSIZE'(1);
                    end else if (accept) begin
                        wcnt <= wcnt + LGSIZE'(1);
                        if (wcnt == CNT_LAST) begin
                            wbank <= ~wbank;
                        end
                    end
                end
                default: wstate <= W_HUNT;
            endcase
        end
    end

    // Write and read only ever touch different banks, so a set and a clear in
    // the same cycle land on different flags and both take effect.
    always_comb begin
        full_next = full;
        if (frame_done) begin
            full_next[wbank] = 1'b1;
        end
        if (read_done) begin
            full_next[rbank] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            full <= '0;
        end else begin
            full <= full_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rbank   <= 1'b0;
            rcnt    <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (issue) begin
            valid_q <= 1'b1;
            first_q <= (rcnt == '0);
            last_q  <= (rcnt == CNT_LAST);
            rcnt    <= rcnt + LGSIZE'(1);
            if (rcnt == CNT_LAST) begin
                rbank <= ~rbank;
            end
        end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    bitrev_dpram #(
        .AW(LGSIZE + 1),
        .DW(2 * WIDTH)
    ) u_ram (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_we   (we),
        .i_waddr({wbank, wr_idx}),
        .i_wdata(i_data),
        .i_re   (issue),
        .i_raddr({rbank, rcnt}),
        .o_rdata(o_data)
    );

    assign o_valid      = valid_q;
    assign o_first      = first_q;
    assign o_last       = last_q;
    assign o_sync_err   = sync_err_q;
    assign o_wstate_dbg = wstate;

endmodule

// File: tb/tb_bitrev_scatter_buffer.sv
// Directed bench for bitrev_scatter_buffer at LGSIZE=3: table-driven frames,
// an expected-output queue checked on every transfer, and corner sequences.
module tb_bitrev_scatter_buffer;
    import fft_pkg::*;

    localparam int LGSIZE = 3;
    localparam int WIDTH  = 16;
    localparam int N      = 1 << LGSIZE;

    logic              i_clk;
    logic              i_reset;
    logic              i_valid;
    logic              o_ready;
    logic              i_sync;
    logic [2*WIDTH-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic [2*WIDTH-1:0] o_data;
    logic              o_first;
    logic              o_last;
    logic              o_sync_err;
    logic [0:0]        o_wstate_dbg;

    bitrev_scatter_buffer #(.LGSIZE(LGSIZE), .WIDTH(WIDTH)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sync      (i_sync),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_first     (o_first),
        .o_last      (o_last),
        .o_sync_err  (o_sync_err),
        .o_wstate_dbg(o_wstate_dbg)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] in_val;
        logic [2:0] exp_val;
        logic       exp_first;
        logic       exp_last;
    } vec_t;

    vec_t tbl [N];

    int checks = 0;
    int errors = 0;
    logic [2*WIDTH+1:0] exp_q [$];
    logic mon_en = 1'b0;
    int cur_run = 0;
    int max_run = 0;
    int sync_cnt = 0;
    logic stall_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2*WIDTH-1:0] d, input logic s);
        int w;
        i_valid = 1'b1;
        i_sync  = s;
        i_data  = d;
        w = 0;
        @(negedge i_clk);
        while (!o_ready && w < 400) begin
            w++;
            @(negedge i_clk);
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got o_ready=0 for %0d cycles, required 1", w);
        end
        if (w > 0) stall_seen = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_sync  = 1'b0;
    endtask

    function automatic logic [2*WIDTH-1:0] word(input logic [15:0] tag, input logic [2:0] v);
        return {tag, 13'd0, v};
    endfunction

    task automatic send_frame(input logic [15:0] tag);
        for (int j = 0; j < N; j++) send(word(tag, tbl[j].in_val), j == 0);
    endtask

    task automatic push_exp(input logic [15:0] tag);
        for (int j = 0; j < N; j++)
            exp_q.push_back({tbl[j].exp_first, tbl[j].exp_last, word(tag, tbl[j].exp_val)});
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            w++;
            @(posedge i_clk);
        end
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_valid) cur_run = cur_run + 1;
            else cur_run = 0;
            if (cur_run > max_run) max_run = cur_run;
            if (o_sync_err) sync_cnt = sync_cnt + 1;
        end
        if (mon_en && !i_reset && o_valid && i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got {first,last,data}=%0h, required no output",
                         {o_first, o_last, o_data});
            end else begin
                logic [2*WIDTH+1:0] e;
                e = exp_q.pop_front();
                if ({o_first, o_last, o_data} !== e) begin
                    errors++;
                    $display("FAIL out_word: got {first,last,data}=%0h, required %0h",
                             {o_first, o_last, o_data}, e);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        // Arrival position j carries value j; natural slot j holds the value
        // that arrived at position bitrev(j).
        tbl[0] = '{3'd0, 3'd0, 1'b1, 1'b0};
        tbl[1] = '{3'd1, 3'd4, 1'b0, 1'b0};
        tbl[2] = '{3'd2, 3'd2, 1'b0, 1'b0};
        tbl[3] = '{3'd3, 3'd6, 1'b0, 1'b0};
        tbl[4] = '{3'd4, 3'd1, 1'b0, 1'b0};
        tbl[5] = '{3'd5, 3'd5, 1'b0, 1'b0};
        tbl[6] = '{3'd6, 3'd3, 1'b0, 1'b0};
        tbl[7] = '{3'd7, 3'd7, 1'b0, 1'b1};

        i_valid = 1'b0;
        i_sync  = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_first", 64'(o_first), 64'd0);
        check("rst_last", 64'(o_last), 64'd0);
        check("rst_sync_err", 64'(o_sync_err), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_wstate", 64'(o_wstate_dbg), 64'(W_HUNT));

        // One frame, explicit latency and ordered compare from the table
        send_frame(16'd1);
        check("lat_pre", 64'(o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        check("lat_rise", 64'(o_valid), 64'd1);
        for (int j = 0; j < N; j++) begin
            check("t1_data", 64'(o_data), 64'(word(16'd1, tbl[j].exp_val)));
            check("t1_first", 64'(o_first), 64'(tbl[j].exp_first));
            check("t1_last", 64'(o_last), 64'(tbl[j].exp_last));
            @(posedge i_clk);
            #1;
        end
        check("t1_valid_fall", 64'(o_valid), 64'd0);

        // Three frames back to back at full rate
        mon_en = 1'b1;
        stall_seen = 1'b0;
        max_run = 0;
        push_exp(16'd2);
        push_exp(16'd3);
        push_exp(16'd4);
        send_frame(16'd2);
        send_frame(16'd3);
        send_frame(16'd4);
        drain("t2_drain");
        check("t2_no_stall", 64'(stall_seen), 64'd0);
        check("t2_valid_run", 64'(max_run), 64'd24);

        // Downstream stalled: both banks fill, 17th sample held
        i_ready = 1'b0;
        push_exp(16'd5);
        push_exp(16'd6);
        push_exp(16'd7);
        send_frame(16'd5);
        send_frame(16'd6);
        check("t3_ready_low", 64'(o_ready), 64'd0);
        check("t3_valid_held", 64'(o_valid), 64'd1);
        check("t3_data_held", 64'(o_data), 64'(word(16'd5, 3'd0)));
        i_valid = 1'b1;
        i_sync  = 1'b1;
        i_data  = word(16'd7, 3'd0);
        repeat (3) begin
            @(posedge i_clk);
            #1;
            check("t3_17th_held", 64'(o_ready), 64'd0);
            check("t3_first_held", 64'(o_first), 64'd1);
        end
        i_ready = 1'b1;
        send_frame(16'd7);
        drain("t3_drain");

        // Sync re-asserted at wcnt=5
        sync_cnt = 0;
        for (int k = 0; k < 5; k++) send(word(16'hEE, 3'(k)), k == 0);
        push_exp(16'd8);
        for (int j = 0; j < N; j++) begin
            send(word(16'd8, tbl[j].in_val), j == 0);
            if (j == 0) check("t4_sync_err_pulse", 64'(o_sync_err), 64'd1);
        end
        drain("t4_drain");
        check("t4_sync_err_count", 64'(sync_cnt), 64'd1);

        // Unsynced samples before the first frame are discarded
        do_reset();
        for (int k = 0; k < 3; k++) send(word(16'hDD, 3'(k)), 1'b0);
        check("t5_still_hunt", 64'(o_wstate_dbg), 64'(W_HUNT));
        push_exp(16'd9);
        send_frame(16'd9);
        check("t5_fill", 64'(o_wstate_dbg), 64'(W_FILL));
        drain("t5_drain");

        // Reset while frame 10 is being output and frame 11 is buffered
        i_ready = 1'b0;
        push_exp(16'd10);
        push_exp(16'd11);
        send_frame(16'd10);
        send_frame(16'd11);
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        check("t6_valid_after_rst", 64'(o_valid), 64'd0);
        check("t6_ready_after_rst", 64'(o_ready), 64'd1);
        check("t6_data_after_rst", 64'(o_data), 64'd0);
        exp_q.delete();
        i_reset = 1'b0;
        i_ready = 1'b1;
        push_exp(16'd12);
        send_frame(16'd12);
        drain("t6_drain");
        repeat (20) @(posedge i_clk);
        #1;
        check("t6_no_stale", 64'(o_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
